// File: rtl/sysid_check_pkg.sv
// Shared types for the system-ID check master.
// State encoding and word offsets within the system-ID slave.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_WAIT,
        S_TS_REQ,
        S_TS_WAIT,
        S_DONE
    } state_e;

    localparam logic [31:0] ID_OFFSET = 32'd0;
    localparam logic [31:0] TS_OFFSET = 32'd4;

    function automatic logic in_ts_phase(state_e s);
        return (s == S_TS_REQ) || (s == S_TS_WAIT);
    endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM pipelined read bus between the check master and the interconnect.
// The master drives command fields; the slave side returns stall and data.
interface sysid_check_master_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sysid_check_master_avm_read_txn.sv
// Single-read Avalon transaction engine with a per-transaction timeout.
// The owning FSM says when it is in the request or wait phase of a read.
module avm_read_txn #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  req_i,
    input  logic                  wait_i,
    input  logic [31:0]           addr_i,
    sysid_check_master_if.master  avm,
    output logic                  acc_o,
    output logic                  hit_o,
    output logic                  tmo_o,
    output logic [31:0]           data_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active;

    assign active          = req_i | wait_i;
    assign avm.avm_read    = req_i;
    assign avm.avm_address = addr_i;

    // Data in the acceptance cycle counts, so zero-latency slaves skip WAIT.
    assign acc_o  = req_i & ~avm.avm_waitrequest;
    assign hit_o  = (acc_o | wait_i) & avm.avm_readdatavalid;
    assign tmo_o  = active & ~hit_o & (cnt_q == LAST);
    assign data_o = avm.avm_readdata;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (active && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sysid_check_master.sv
// Reads the system-ID and timestamp words and compares them with build values.
// Sticky results hold until the next check is launched.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h58CF_EF29,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    sysid_check_master_if.master  avm,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  id_ok,
    output logic                  ts_ok,
    output logic                  timeout,
    output logic [31:0]           captured_id,
    output logic [31:0]           captured_ts
);

    state_e      state_q, state_d;
    logic        auto_q;
    logic        go;
    logic        req, wt, clr;
    logic [31:0] addr;
    logic        acc, hit, tmo;
    logic [31:0] rdata;
    logic        done_q, pass_q, id_ok_q, ts_ok_q, tmo_q;
    logic [31:0] cap_id_q, cap_ts_q;

    assign go = start | auto_q;

    avm_read_txn #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_txn (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (clr),
        .req_i  (req),
        .wait_i (wt),
        .addr_i (addr),
        .avm    (avm),
        .acc_o  (acc),
        .hit_o  (hit),
        .tmo_o  (tmo),
        .data_o (rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) state_d = S_ID_REQ;
            end
            S_ID_REQ: begin
                if (hit)      state_d = S_TS_REQ;
                else if (tmo) state_d = S_DONE;
                else if (acc) state_d = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                if (hit)      state_d = S_TS_REQ;
                else if (tmo) state_d = S_DONE;
            end
            S_TS_REQ: begin
                if (hit)      state_d = S_DONE;
                else if (tmo) state_d = S_DONE;
                else if (acc) state_d = S_TS_WAIT;
            end
            S_TS_WAIT: begin
                if (hit || tmo) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        req  = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
        wt   = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
        addr = in_ts_phase(state_q) ? BASE_ADDR + TS_OFFSET
                                    : BASE_ADDR + ID_OFFSET;
        // Restart the timeout budget whenever a new request phase begins.
        clr  = ((state_d == S_ID_REQ) || (state_d == S_TS_REQ))
               && (state_d != state_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_q   <= 1'(AUTO_START != 0);
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
            cap_id_q <= '0;
            cap_ts_q <= '0;
        end else begin
            auto_q <= 1'b0;
            if (state_q == S_IDLE && go) begin
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
                id_ok_q <= 1'b0;
                ts_ok_q <= 1'b0;
                tmo_q   <= 1'b0;
            end
            if (hit && !in_ts_phase(state_q)) begin
                cap_id_q <= rdata;
                id_ok_q  <= (rdata == EXPECTED_ID);
            end
            if (hit && in_ts_phase(state_q)) begin
                cap_ts_q <= rdata;
                ts_ok_q  <= (rdata == EXPECTED_TS);
            end
            if (tmo) begin
                tmo_q <= 1'b1;
            end
            if (state_q == S_DONE) begin
                pass_q <= id_ok_q & ts_ok_q & ~tmo_q;
                done_q <= 1'b1;
            end
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = tmo_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master with a configurable Avalon slave.
// Expected results come from a per-check arithmetic model of the outcome.
module tb_sysid_check_master;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h58CF_EF29;
    localparam int          T      = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sysid_check_master_if bus ();

    sysid_check_master #(
        .BASE_ADDR      (BASE),
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (T),
        .AUTO_START     (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (bus),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout     (timeout),
        .captured_id (captured_id),
        .captured_ts (captured_ts)
    );

    // Slave configuration, changed by the stimulus only between checks.
    int          cfg_w = 0;
    int          cfg_l = 0;
    bit          cfg_mute = 0;
    bit          cfg_spur = 0;
    logic [31:0] cfg_id = EXP_ID;
    logic [31:0] cfg_ts = EXP_TS;

    int          st_cnt;
    logic        pv [8];
    logic [31:0] pd [8];
    logic        acc, acc_s, ws_s;
    logic [31:0] sel, sel_s, last_addr;
    int          n_acc = 0;
    int          n_ts = 0;
    int          stall_err = 0;
    logic        ts_acc_s;

    always_comb begin
        bus.avm_waitrequest = bus.avm_read && (st_cnt < cfg_w);
        acc = bus.avm_read && !bus.avm_waitrequest;
        sel = (bus.avm_address == BASE + 32'd4) ? cfg_ts : cfg_id;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata = 32'hDEAD_BEEF;
        if (pv[0]) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = pd[0];
        end else if (acc && cfg_l == 0 && !cfg_mute) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = sel;
        end else if (cfg_spur &&
                     ((bus.avm_read && bus.avm_waitrequest) || !busy)) begin
            bus.avm_readdatavalid = 1'b1;
        end
    end

    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_s    <= 1'b0;
            ws_s     <= 1'b0;
            sel_s    <= '0;
            ts_acc_s <= 1'b0;
        end else begin
            if (ws_s && (!bus.avm_read || bus.avm_address != last_addr))
                stall_err <= stall_err + 1;
            acc_s     <= acc;
            ws_s      <= bus.avm_read && bus.avm_waitrequest;
            sel_s     <= sel;
            ts_acc_s  <= acc && (bus.avm_address == BASE + 32'd4);
            last_addr <= bus.avm_address;
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_cnt <= 0;
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            st_cnt <= ws_s ? st_cnt + 1 : 0;
            for (int i = 0; i < 7; i++) begin
                pv[i] <= pv[i+1];
                pd[i] <= pd[i+1];
            end
            pv[7] <= 1'b0;
            if (acc_s && cfg_l > 0 && !cfg_mute) begin
                pv[cfg_l-1] <= 1'b1;
                pd[cfg_l-1] <= sel_s;
            end
            if (acc_s) n_acc <= n_acc + 1;
            if (ts_acc_s) n_ts <= n_ts + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] m_cap_id = '0;
    logic [31:0] m_cap_ts = '0;

    // Runs one check (by start pulse or auto-start) and scores the outcome.
    task automatic run_check(input bit use_start, input bit do_poke,
                             input string tag);
        int  phase, exp_n, lim, poke_at, n, a0, t0, e0;
        bit  seen, m_id, m_ts, m_pass;
        phase = cfg_w + 1 + cfg_l;
        exp_n = 2 * phase + 2;
        lim   = cfg_mute ? T : exp_n - 1;
        poke_at = do_poke ? int'($urandom_range(1, lim)) : 0;
        m_id   = !cfg_mute && (cfg_id == EXP_ID);
        m_ts   = !cfg_mute && (cfg_ts == EXP_TS);
        m_pass = m_id && m_ts;
        if (!cfg_mute) begin
            m_cap_id = cfg_id;
            m_cap_ts = cfg_ts;
        end
        a0 = n_acc;
        t0 = n_ts;
        e0 = stall_err;
        seen = 0;
        n = 0;
        if (use_start) start = 1'b1;
        while (!seen && n < 60) begin
            @(posedge clock);
            @(negedge clock);
            n++;
            start = (n == poke_at);
            if (done) seen = 1;
        end
        start = 1'b0;
        chk({tag, ":done"}, 32'(seen), 32'd1);
        if (cfg_mute)
            chk({tag, ":tmo_lat"}, 32'(n >= T && n <= T + 2), 32'd1);
        else
            chk({tag, ":latency"}, n, exp_n);
        chk({tag, ":pass"}, 32'(pass), 32'(m_pass));
        chk({tag, ":id_ok"}, 32'(id_ok), 32'(m_id));
        chk({tag, ":ts_ok"}, 32'(ts_ok), 32'(m_ts));
        chk({tag, ":timeout"}, 32'(timeout), 32'(cfg_mute));
        chk({tag, ":cap_id"}, captured_id, m_cap_id);
        chk({tag, ":cap_ts"}, captured_ts, m_cap_ts);
        chk({tag, ":reads"}, n_acc - a0, cfg_mute ? 1 : 2);
        chk({tag, ":ts_reads"}, n_ts - t0, cfg_mute ? 0 : 1);
        chk({tag, ":stall"}, stall_err - e0, 0);
        repeat (3) @(negedge clock);
        chk({tag, ":idle_after"}, 32'(busy), 32'd0);
        chk({tag, ":sticky"}, 32'(done), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":busy"}, 32'(busy), 0);
        chk({tag, ":done"}, 32'(done), 0);
        chk({tag, ":pass"}, 32'(pass), 0);
        chk({tag, ":id_ok"}, 32'(id_ok), 0);
        chk({tag, ":ts_ok"}, 32'(ts_ok), 0);
        chk({tag, ":timeout"}, 32'(timeout), 0);
        chk({tag, ":cap_id"}, captured_id, 0);
        chk({tag, ":cap_ts"}, captured_ts, 0);
        chk({tag, ":read"}, 32'(bus.avm_read), 0);
        chk({tag, ":addr"}, bus.avm_address, BASE);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1 chk_reset_outputs("rst");
        @(negedge clock);
        reset_n = 1'b1;
        run_check(0, 0, "auto0");

        cfg_ts = 32'h58CF_EF28;
        run_check(1, 0, "ts_bad");

        cfg_ts = EXP_TS;
        cfg_w = 3;
        cfg_l = 2;
        run_check(1, 0, "stall");

        cfg_w = 0;
        cfg_l = 0;
        cfg_mute = 1;
        run_check(1, 0, "mute");

        cfg_mute = 0;
        cfg_w = 1;
        cfg_l = 1;
        run_check(1, 1, "poke");
        run_check(1, 0, "rerun");

        cfg_w = 0;
        cfg_l = 3;
        cfg_id = 32'h1234_5678;
        start = 1'b1;
        repeat (6) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
        end
        chk("ts_wait:busy", 32'(busy), 1);
        chk("ts_wait:addr", bus.avm_address, BASE + 32'd4);
        chk("ts_wait:read", 32'(bus.avm_read), 0);
        chk("ts_wait:cap_id", captured_id, 32'h1234_5678);
        reset_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        m_cap_id = '0;
        m_cap_ts = '0;
        @(negedge clock);
        reset_n = 1'b1;
        run_check(0, 0, "auto1");

        for (int k = 0; k < 25; k++) begin
            int tsel;
            cfg_w    = $urandom_range(0, 3);
            cfg_l    = $urandom_range(0, 3);
            cfg_mute = ($urandom_range(0, 5) == 0);
            cfg_spur = cfg_mute ? 1'b0 : 1'($urandom_range(0, 1));
            cfg_id   = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
            tsel     = $urandom_range(0, 2);
            cfg_ts   = (tsel == 0) ? EXP_TS :
                       (tsel == 1) ? EXP_TS ^ (32'd1 << $urandom_range(0, 31)) :
                                     $urandom;
            run_check(1, ($urandom_range(0, 2) == 0), $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that interrogates the system-ID slave over the interconnect and compares both words against build-time expected values.
- Sits beside the CPU in the Qsys system.
- Raises a sticky pass/fail result that boot firmware polls, and that can gate peripheral release, so a mismatched .sof/.elf pairing is caught in hardware.
- Runs once after reset, or on demand through `start`.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the system-ID slave on the master's address map
- EXPECTED_ID, 32'h0000_0000, value required at word offset 0
- EXPECTED_TS, 32'h58CF_EF29, value required at word offset 1
- TIMEOUT_CYCLES, 256, maximum clocks per read transaction before abort; must be ≥2
- AUTO_START, 1, 1 = launch a check on the first cycle after reset release

Ports:
- clock, input, 1, system clock
- reset_n, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle pulse; begins a check when not busy
- avm_address, output, 32, byte address (BASE_ADDR or BASE_ADDR+4)
- avm_read, output, 1, read request
- avm_waitrequest, input, 1, interconnect stall
- avm_readdata, input, 32, read data
- avm_readdatavalid, input, 1, read data qualifier (pipelined read)
- busy, output, 1, check in progress
- done, output, 1, sticky; check finished
- pass, output, 1, sticky; both words matched, no timeout
- id_ok, output, 1, ID word matched
- ts_ok, output, 1, timestamp word matched
- timeout, output, 1, a transaction exceeded TIMEOUT_CYCLES
- captured_id, output, 32, last ID word read
- captured_ts, output, 32, last timestamp word read

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n). All registers clear on reset_n low.
- Reset values: every output is 0, and avm_address = BASE_ADDR.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE:
  - Go to ID_REQ when start = 1, or on the first cycle after reset release if AUTO_START = 1 (one-shot flag).
  - On entry to a check, clear done, pass, id_ok, ts_ok and timeout, and clear the timeout counter.
- ID_REQ:
  - avm_read = 1, avm_address = BASE_ADDR.
  - Hold address and read stable while avm_waitrequest = 1.
  - The command is accepted on the first cycle with avm_waitrequest = 0; then go to ID_WAIT.
- ID_WAIT:
  - avm_read = 0.
  - On avm_readdatavalid = 1: register captured_id, set id_ok = (readdata == EXPECTED_ID), go to TS_REQ.
  - If readdatavalid is asserted in the same cycle as command acceptance (zero-latency slave), capture directly from ID_REQ and skip ID_WAIT.
- TS_REQ / TS_WAIT: identical to the ID phase, using address BASE_ADDR+4, captured_ts and ts_ok. Then go to DONE.
- DONE:
  - Set pass = id_ok & ts_ok & ~timeout, set done = 1, return to IDLE.
  - Results hold until the next check starts.
- busy = 1 in every state except IDLE.
- Timeout:
  - A per-transaction counter clears on entry to each REQ state and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES-1 sets timeout = 1, deasserts avm_read, and goes directly to DONE. The other ok flags stay 0 for the unfinished phase.
- start while busy is ignored, with no queueing.
- start in the same cycle DONE returns to IDLE is also ignored.
- A spurious avm_readdatavalid in IDLE or a REQ state before acceptance is ignored.
- Reset asserted mid-transaction aborts immediately; the AUTO_START one-shot rearms.
- Latency: with a zero-wait slave of read latency L, a check completes (done rising) 2·(L+1)+2 cycles after start.

Decomposition:
- Shared package sysid_check_pkg holds:
  - the state enum
  - the word offset constants ID_OFFSET = 0 and TS_OFFSET = 4
- Sub-module avm_read_txn: single-read Avalon transaction engine with timeout. It is instantiated once and sequenced twice by the top FSM.

Test Plan:
- Zero-latency slave returning 0 at offset 0 and 32'h58CFEF29 at offset 4, AUTO_START = 1 → after reset release, done = 1, pass = 1, captured_ts = 32'h58CFEF29, done rising 4 cycles after the first active cycle.
- Slave returns 32'h58CFEF28 at offset 4 → id_ok = 1, ts_ok = 0, pass = 0, done = 1.
- waitrequest held 3 cycles on each read, readdatavalid latency 2 → address and read stable throughout the stall, exactly 2 accepted reads, pass = 1.
- readdatavalid never asserted, TIMEOUT_CYCLES = 16 → timeout = 1 and done = 1 at cycle 16 of the ID phase, pass = 0, no TS read issued.
- start pulsed while busy, then again after done → first pulse ignored; second pulse clears the flags and reruns, with identical results.
- reset_n dropped during TS_WAIT → all outputs 0 asynchronously; after release the check reruns automatically.
